// File: rtl/frame_loader_pkg.sv
// frame_loader_pkg: FSM state type shared by the frame loader
package frame_loader_pkg;
  typedef enum logic [1:0] {IDLE, HI, LO, GO} state_t;
endpackage

// File: rtl/frame_loader.sv
// frame_loader: assembles an RGB565 byte stream into upper/lower panel bank writes
module frame_loader
  import frame_loader_pkg::*;
#(
  parameter int MATRIX_HEIGHT = 32,
  parameter int MATRIX_WIDTH = 64,
  localparam int BANK_SIZE = MATRIX_HEIGHT * MATRIX_WIDTH / 2,
  localparam int AW = $clog2(BANK_SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  input  logic          in_sof,
  output logic          in_ready,
  output logic [15:0]   w_data,
  output logic [AW-1:0] w_addr,
  output logic          bank0_wen,
  output logic          bank1_wen,
  output logic          go,
  output logic          frame_err
);
  localparam int NPIX = MATRIX_HEIGHT * MATRIX_WIDTH;
  localparam int PW = $clog2(NPIX);
  localparam logic [PW-1:0] LAST = PW'(NPIX - 1);
  localparam logic [PW-1:0] BANK_PIX = PW'(BANK_SIZE);
  state_t state, state_nxt;
  logic [PW-1:0] pix;
  logic [7:0] hi;
  logic acc, restart, capture_hi, complete, bank1;
  assign in_ready = !rst && state != GO;
  assign go = state == GO;
  assign acc = in_valid && in_ready;
  // pixels past the first half-panel land in the lower bank at the same row-major offset
  assign bank1 = pix >= BANK_PIX;
  always_comb begin
    restart = acc && in_sof;
    capture_hi = acc && !in_sof && state == HI;
    complete = acc && !in_sof && state == LO;
    state_nxt = restart || capture_hi ? LO
              : complete ? (pix == LAST ? GO : HI)
              : state == GO ? IDLE
              : state;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pix <= '0;
      hi <= '0;
      w_data <= '0;
      w_addr <= '0;
      bank0_wen <= 1'b0;
      bank1_wen <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= restart && state != IDLE;
      bank0_wen <= complete && !bank1;
      bank1_wen <= complete && bank1;
      if (restart || capture_hi) hi <= in_data;
      if (restart) pix <= '0;
      else if (complete && pix != LAST) pix <= pix + PW'(1);
      if (complete) begin
        w_data <= {hi, in_data};
        w_addr <= AW'(bank1 ? pix - BANK_PIX : pix);
      end
    end
  end
endmodule

// File: tb/tb_frame_loader.sv
// tb_frame_loader: randomized scoreboard bench for frame_loader on a 4x8 panel
module tb_frame_loader;
  localparam int H = 4, W = 8, BS = H * W / 2, AW = $clog2(BS);
  logic clk = 0, rst = 1;
  logic [7:0] in_data = 0;
  logic in_valid = 0, in_sof = 0;
  logic in_ready, bank0_wen, bank1_wen, go, frame_err;
  logic [15:0] w_data;
  logic [AW-1:0] w_addr;

  frame_loader #(.MATRIX_HEIGHT(H), .MATRIX_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
    .in_ready(in_ready), .w_data(w_data), .w_addr(w_addr), .bank0_wen(bank0_wen),
    .bank1_wen(bank1_wen), .go(go), .frame_err(frame_err));

  always #5 clk = ~clk;

  typedef struct {int kind; int bank; int addr; int data; int cyc;} ev_t;
  ev_t q[$];
  int tests = 0, fails = 0, cyc = 0, gap_pct = 0;
  int mem0[BS], mem1[BS];
  bit in_frame = 0, have_hi = 0;
  int p = 0;
  logic [7:0] hi_b;

  task automatic expect_eq(input string name, input int got, input int req);
    tests++;
    if (got != req) begin
      fails++;
      $display("FAIL %s got %0d required %0d", name, got, req);
    end
  endtask

  task automatic chk(input int kind, input int bank, input int addr, input int data);
    ev_t e;
    tests++;
    if (q.size() == 0) begin
      fails++;
      $display("FAIL unexpected event kind=%0d bank=%0d addr=%0d data=%h cyc=%0d, required none", kind, bank, addr, data, cyc);
      return;
    end
    e = q.pop_front();
    if (e.kind != kind || e.cyc != cyc || (kind == 0 && (e.bank != bank || e.addr != addr || e.data != data))) begin
      fails++;
      $display("FAIL event got kind=%0d bank=%0d addr=%0d data=%h cyc=%0d, required kind=%0d bank=%0d addr=%0d data=%h cyc=%0d",
               kind, bank, addr, data, cyc, e.kind, e.bank, e.addr, e.data, e.cyc);
    end
  endtask

  // monitor: kinds 0=write, 1=go, 2=frame_err
  always @(negedge clk) begin
    cyc++;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      tests++;
      fails++;
      $display("FAIL missed event kind=%0d addr=%0d, required at cyc %0d now %0d", q[0].kind, q[0].addr, q[0].cyc, cyc);
      void'(q.pop_front());
    end
    if (bank0_wen && bank1_wen) expect_eq("both_wen", 1, 0);
    if (bank0_wen || bank1_wen) chk(0, bank1_wen ? 1 : 0, int'(w_addr), int'(w_data));
    if (bank0_wen) mem0[w_addr] = int'(w_data);
    if (bank1_wen) mem1[w_addr] = int'(w_data);
    if (go) chk(1, 0, 0, 0);
    if (frame_err) chk(2, 0, 0, 0);
  end

  // reference model: frame position tracked as a pixel index plus pending high byte
  task automatic model(input logic [7:0] d, input bit s);
    ev_t e;
    int row, col;
    e.cyc = cyc + 1; e.bank = 0; e.addr = 0; e.data = 0;
    if (s) begin
      if (in_frame) begin e.kind = 2; q.push_back(e); end
      in_frame = 1; p = 0; hi_b = d; have_hi = 1;
    end else if (!in_frame) begin
    end else if (!have_hi) begin
      hi_b = d; have_hi = 1;
    end else begin
      row = p / W; col = p % W;
      e.kind = 0; e.bank = row >= H / 2 ? 1 : 0; e.addr = (row % (H / 2)) * W + col;
      e.data = int'({hi_b, d});
      q.push_back(e);
      have_hi = 0;
      if (p == H * W - 1) begin e.kind = 1; q.push_back(e); in_frame = 0; end
      else p++;
    end
  endtask

  task automatic send(input logic [7:0] d, input bit s);
    if ($urandom_range(99) < gap_pct) repeat ($urandom_range(1, 3)) @(negedge clk);
    for (int n = 0; ; n++) begin
      @(negedge clk); #2;
      in_valid = 1; in_data = d; in_sof = s;
      #1;
      if (in_ready) begin
        model(d, s);
        @(posedge clk); #1;
        break;
      end
      if (n == 20) begin
        expect_eq("ready_timeout", 0, 1);
        break;
      end
    end
    in_valid = 0; in_sof = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst = 1;
    #1 expect_eq("rst_in_ready", int'(in_ready), 0);
    @(negedge clk); #1;
    expect_eq("rst_outs", int'({go, frame_err, bank0_wen, bank1_wen}), 0);
    expect_eq("rst_w_addr", int'(w_addr), 0);
    expect_eq("rst_w_data", int'(w_data), 0);
    #1 rst = 0;
    in_frame = 0; have_hi = 0;
  endtask

  function automatic logic [15:0] pat(input int i);
    logic [15:0] v;
    v = 16'((i << 11) | (i << 5) | i);
    return v;
  endfunction

  task automatic frame(input int npix, input bit use_pat, input int gap_at);
    logic [15:0] v;
    for (int i = 0; i < npix; i++) begin
      v = use_pat ? pat(i) : 16'($urandom);
      send(v[15:8], i == 0);
      if (i == gap_at) repeat (3) @(negedge clk);
      send(v[7:0], 0);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    do_reset();
    send(8'hAB, 0);
    send(8'hCD, 0);
    repeat (3) @(negedge clk);
    expect_eq("no_sof_pending", q.size(), 0);
    send(8'h12, 1);
    send(8'h34, 0);
    do_reset();
    foreach (mem0[i]) begin mem0[i] = -1; mem1[i] = -1; end
    frame(H * W, 1, -1);
    repeat (3) @(negedge clk);
    for (int a = 0; a < BS; a++) begin
      expect_eq($sformatf("bank0[%0d]", a), mem0[a], int'(pat(a)));
      expect_eq($sformatf("bank1[%0d]", a), mem1[a], int'(pat(a + BS)));
    end
    frame(10, 0, -1);
    frame(H * W, 0, -1);
    frame(H * W, 0, 17);
    gap_pct = 30;
    frame(H * W, 0, -1);
    gap_pct = 0;
    for (int i = 0; i < 40; i++) send(8'($urandom), i == 0);
    do_reset();
    frame(H * W, 0, -1);
    gap_pct = 20;
    for (int i = 0; i < 300; i++) send(8'($urandom), $urandom_range(39) == 0);
    repeat (5) @(negedge clk);
    expect_eq("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
